riscv_mem: RTL

Memory-access pipeline stage directly downstream of the execute stage. It consumes the EX result, memory function, store data and destination register. It performs byte, half or word loads and stores over a single-outstanding data-memory request/ack bus, aligns and extends load data, and presents a writeback record to the WB stage. Non-memory operations pass through with 1-cycle latency.

---
 rtl/riscv_mem.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/riscv_mem.sv
// riscv_mem: memory-access stage between EX and WB. It runs byte, half and word loads and
//   stores over a single-outstanding req/ack data bus, aligns and extends load data, and
//   emits an in-order writeback record.
// Latency: non-memory records take 1 cycle. Memory records take 2 cycles plus dmem wait states.
// Backpressure: ds_ack rises only in IDLE with a free output slot. us_rdy and mem_wb_* hold until us_ack.
// Ports: clk, rst (synchronous, active-high) | ds_rdy/ds_ack + ex_mem_* (EX record in) |
//   dmem_req/we/addr/sel/wdata/ack/rdata (data bus) | us_rdy/us_ack + mem_wb_* (WB record out).
// Option: define MEM_MISALIGN_TRAP_EN to add mem_wb_misalign. Misaligned accesses then skip
//   the bus and return a flagged record.

`ifndef RISCV_FUNCTIONS_VH
`define RISCV_FUNCTIONS_VH
`define MEM_FUNCT_W 4
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LH  4'd2
`define MEM_LW  4'd3
`define MEM_LBU 4'd4
`define MEM_LHU 4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif

module riscv_mem #(
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ds_rdy,
  output logic                    ds_ack,
  input  logic [31:0]             ex_mem_result,
  input  logic [`MEM_FUNCT_W-1:0] ex_mem_funct,
  input  logic [31:0]             ex_mem_data,
  input  logic [4:0]              ex_mem_wb_rsd,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [ADDR_W-1:0]       dmem_addr,
  output logic [3:0]              dmem_sel,
  output logic [31:0]             dmem_wdata,
  input  logic                    dmem_ack,
  input  logic [31:0]             dmem_rdata,
  output logic                    us_rdy,
  input  logic                    us_ack,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                    mem_wb_misalign,
`endif
  output logic [31:0]             mem_wb_data,
  output logic [4:0]              mem_wb_rsd,
  output logic                    mem_wb_we
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [0:0]  r_state;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [1:0]  r_lane;
  logic [4:0]  r_rsd;

  logic        w_slot_free;
  logic        w_xfer;
  logic        w_is_mem;
  logic        w_is_store;
  logic [1:0]  w_size;
  logic        w_sign;
  logic [1:0]  w_lane;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic        w_trap;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_slot_free = !us_rdy || us_ack;
  // Held low during reset, so nothing is accepted while the stage is clearing.
  assign ds_ack      = !rst && (r_state == S_IDLE) && w_slot_free;
  assign w_xfer      = ds_rdy && ds_ack;
  assign w_lane      = ex_mem_result[1:0];

  // Unknown function codes fall through as NOPs.
  always_comb begin
    w_is_mem   = 1'b0;
    w_is_store = 1'b0;
    w_size     = SZ_W;
    w_sign     = 1'b0;
    case (ex_mem_funct)
      `MEM_LB:  begin w_is_mem = 1'b1; w_size = SZ_B; w_sign = 1'b1; end
      `MEM_LH:  begin w_is_mem = 1'b1; w_size = SZ_H; w_sign = 1'b1; end
      `MEM_LW:  begin w_is_mem = 1'b1; w_size = SZ_W; end
      `MEM_LBU: begin w_is_mem = 1'b1; w_size = SZ_B; end
      `MEM_LHU: begin w_is_mem = 1'b1; w_size = SZ_H; end
      `MEM_SB:  begin w_is_mem = 1'b1; w_is_store = 1'b1; w_size = SZ_B; end
      `MEM_SH:  begin w_is_mem = 1'b1; w_is_store = 1'b1; w_size = SZ_H; end
      `MEM_SW:  begin w_is_mem = 1'b1; w_is_store = 1'b1; w_size = SZ_W; end
      default:  ;
    endcase
  end

  // Without the misalignment trap, the low address bits only pick lanes. A half-word uses
  // bit 1 alone, and a word ignores both bits.
  always_comb begin
    case (w_size)
      SZ_B: begin
        w_sel   = 4'b0001 << w_lane;
        w_wdata = {4{ex_mem_data[7:0]}};
      end
      SZ_H: begin
        w_sel   = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{ex_mem_data[15:0]}};
      end
      default: begin
        w_sel   = 4'hF;
        w_wdata = ex_mem_data;
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = w_is_mem && (((w_size == SZ_H) && w_lane[0]) ||
                               ((w_size == SZ_W) && (w_lane != 2'b00)));
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    case (r_lane)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_size)
      SZ_B:    w_load_data = {{24{r_sign & w_byte[7]}}, w_byte};
      SZ_H:    w_load_data = {{16{r_sign & w_half[15]}}, w_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_size      <= SZ_W;
      r_sign      <= 1'b0;
      r_lane      <= 2'd0;
      r_rsd       <= 5'd0;
      us_rdy      <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_sel    <= 4'd0;
      dmem_wdata  <= 32'd0;
      mem_wb_data <= 32'd0;
      mem_wb_rsd  <= 5'd0;
      mem_wb_we   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_wb_misalign <= 1'b0;
`endif
    end else begin
      // The current record leaves this edge. A same-edge NOP transfer overrides this clear.
      if (us_rdy && us_ack) us_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            if (w_is_mem && !w_trap) begin
              r_state    <= S_ACCESS;
              r_size     <= w_size;
              r_sign     <= w_sign;
              r_lane     <= w_lane;
              r_rsd      <= ex_mem_wb_rsd;
              dmem_req   <= 1'b1;
              dmem_we    <= w_is_store;
              dmem_addr  <= {ex_mem_result[ADDR_W-1:2], 2'b00};
              dmem_sel   <= w_sel;
              dmem_wdata <= w_wdata;
            end else begin
              us_rdy      <= 1'b1;
              mem_wb_data <= ex_mem_result;
              mem_wb_rsd  <= ex_mem_wb_rsd;
              mem_wb_we   <= !w_trap && (ex_mem_wb_rsd != 5'd0);
`ifdef MEM_MISALIGN_TRAP_EN
              mem_wb_misalign <= w_trap;
`endif
            end
          end
        end
        S_ACCESS: begin
          // The output slot is always empty here, because entering ACCESS required a free slot.
          if (dmem_ack) begin
            r_state     <= S_IDLE;
            dmem_req    <= 1'b0;
            us_rdy      <= 1'b1;
            mem_wb_rsd  <= r_rsd;
            mem_wb_data <= dmem_we ? 32'd0 : w_load_data;
            mem_wb_we   <= !dmem_we && (r_rsd != 5'd0);
`ifdef MEM_MISALIGN_TRAP_EN
            mem_wb_misalign <= 1'b0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
